shift_exec_stage: RTL
=====================

# shift_exec_stage

Execute-stage wrapper that feeds the 64-bit combinational `Shift` unit for RV64 shift instructions (SLL/SRL/SRA and the W forms). It accepts decoded operands from ID over a valid/ready handshake and decodes funct3/funct7[5]/word into `shift_control`. It also masks the shift amount, drives `Shift`, and returns a registered, sign-correct result to the write-back path. The block is a two-stage pipeline with full-throughput backpressure, a flush, and an illegal-op flag.

## Interface
- `XLEN`, 64, datapath width. Only 64 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of all in-flight entries.
- `in_valid` input 1: the ID stage presents an operation.
- `in_ready` output 1: the stage can accept an operation this cycle.
- `in_funct3` input 3: instruction funct3. 001 is a left shift; 101 is a right shift.
- `in_funct7_5` input 1: instruction bit 30. 1 selects arithmetic for a right shift.
- `in_is_word` input 1: W-form instruction (SLLW, SRLW, SRAW, and the immediate forms).
- `in_rs1` input 64: value to be shifted.
- `in_rs2` input 64: shift amount (rs2 value or the immediate already selected by ID).
- `in_rd` input 5: destination register tag, carried through unchanged.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: write-back accepts the result.
- `out_data` output 64: shift result.
- `out_rd` output 5: destination tag.
- `out_err` output 1: illegal funct3. `out_data` is 0 when this is set.

## Operation
- Handshakes:
  - An input fires when `in_valid & in_ready`.
  - An output fires when `out_valid & out_ready`.
  - `out_*` stay stable while `out_valid & !out_ready`.
- Stage 1 (S1) registers hold `s1_valid`, the decoded `ctl[2:0]`, the masked shamt[5:0], `rs1`, `rd`, and `err`.
- Decode into `ctl`:
  - funct3 001: LogicalLeft32 (010) if `is_word`, else LogicalLeft64 (100).
  - funct3 101 with funct7_5=0: LogicalRight32 (001) if word, else LogicalRight64 (011).
  - funct3 101 with funct7_5=1: ArithRight32 (000) if word, else ArithRight64 (101).
  - Any other funct3: `err`=1 and `ctl`=LogicalLeft64.
- Shamt mask: word ops use `in_rs2[4:0]` zero-extended. 64-bit ops use `in_rs2[5:0]`. Higher bits are ignored.
- `Shift` is driven combinationally from the S1 registers: `src1`=`s1_rs1`, `src2`={58'b0, `s1_shamt`}, `shift_control`=`s1_ctl`.
- Stage 2 (S2) registers capture `shift_out` (forced to 0 if `err`), `rd`, and `err`, and drive `out_*` directly.
- W-form results are the 32-bit result sign-extended from bit 31. This holds for SRLW as well.

## Timing
- Reset (async, `rst`=1): `s1_valid`=0, `s2_valid`=0, `out_valid`=0, `out_data`=0, `out_rd`=0, `out_err`=0. The data registers clear too.
- Latency: an input that fires at edge N gives `out_valid`=1 after edge N+1 (two register stages, data visible in the cycle after the second capture). With `out_ready` held high, throughput is one operation per cycle.
- S2 advances when `s2_adv = !s2_valid | out_ready`.
- S1 advances into S2 when `s1_valid & s2_adv`.
- `in_ready = !s1_valid | s2_adv`. This is a combinational path from `out_ready`, and it is intentional.
- Full: both stages valid with `out_ready`=0 gives `in_ready`=0. Nothing is dropped or reordered.
- Simultaneous output fire and input fire with both stages full: S1 shifts into S2 and the new input enters S1 in the same edge.
- `flush`=1 at an edge: `s1_valid` and `s2_valid` become 0. Any input firing in that cycle is discarded. Flush has priority over every other update. `in_ready` is unaffected by `flush`.
- `rst` asserted mid-operation: all state clears immediately, with no partial output. Normal behaviour resumes on the first edge after deassert.

## Structure
- Shared package `alu_pkg` holds the `shift_control` encodings:
  - ArithRight32=000, LogicalRight32=001, LogicalLeft32=010
  - LogicalRight64=011, LogicalLeft64=100, ArithRight64=101
- `alu_pkg` also holds the funct3 constants `F3_SLL`=001 and `F3_SR`=101.
- Sub-module: one instance of `Shift` (ports `src1`, `src2`, `shift_control`, `shift_out`).
- Decode and pipeline control are inline.

## Test plan
- SLL: rs1=0x1, rs2=63, word=0 -> `out_data`=0x8000_0000_0000_0000, arriving two edges after acceptance.
- SRAW: rs1=0x0000_0000_8000_0000, rs2=4, funct7_5=1 -> 0xFFFF_FFFF_F800_0000.
- Shamt masking:
  - SRLW: rs1=0xFFFF_FFFF_8000_0000, rs2=0x24 (shamt 4) -> 0x0000_0000_0800_0000.
  - SRA: rs1=0x8000_0000_0000_0000, rs2=0x47 (shamt 7) -> 0xFF00_0000_0000_0000.
  - SLLW: rs1=0x1, rs2=31 -> 0xFFFF_FFFF_8000_0000.
- Backpressure: hold `out_ready`=0 for 4 cycles while offering three SLL ops (shamt 1, 2, 3 on rs1=1).
  - `in_ready` drops after two ops are accepted.
  - On release, the outputs appear in order: 0x2, 0x4, 0x8.
- Illegal op and flush:
  - funct3=000 -> `out_err`=1 and `out_data`=0.
  - Flush with both stages full -> `out_valid`=0 on the next cycle, and the next accepted op completes normally.
- Reset: assert `rst` asynchronously mid-stream -> `out_valid`=0 and `out_data`=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: shift_control codes for the Shift unit and RV64 shift funct3 values.
package alu_pkg;

    typedef enum logic [2:0] {
        ARITH_RIGHT32   = 3'b000,
        LOGICAL_RIGHT32 = 3'b001,
        LOGICAL_LEFT32  = 3'b010,
        LOGICAL_RIGHT64 = 3'b011,
        LOGICAL_LEFT64  = 3'b100,
        ARITH_RIGHT64   = 3'b101
    } shift_ctl_e;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/shift_exec_stage_shift.sv
// Combinational 64-bit shifter. W-form results are sign-extended from bit 31,
// including logical right shifts, to match RV64 *W semantics.
module Shift
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  shift_ctl_e      shift_control,
    output logic [XLEN-1:0] shift_out
);

    logic [4:0]  sh32;
    logic [5:0]  sh64;
    logic [31:0] r32;
    logic        src2_unused;

    assign sh32        = src2[4:0];
    assign sh64        = src2[5:0];
    assign src2_unused = ^src2[XLEN-1:6];

    always_comb begin
        r32       = '0;
        shift_out = '0;
        case (shift_control)
            ARITH_RIGHT32:   r32 = 32'($signed(src1[31:0]) >>> sh32);
            LOGICAL_RIGHT32: r32 = src1[31:0] >> sh32;
            LOGICAL_LEFT32:  r32 = src1[31:0] << sh32;
            LOGICAL_RIGHT64: shift_out = src1 >> sh64;
            LOGICAL_LEFT64:  shift_out = src1 << sh64;
            ARITH_RIGHT64:   shift_out = XLEN'($signed(src1) >>> sh64);
            default:         shift_out = '0;
        endcase
        if (shift_control inside {ARITH_RIGHT32, LOGICAL_RIGHT32, LOGICAL_LEFT32})
            shift_out = {{(XLEN-32){r32[31]}}, r32};
    end

endmodule

// File: rtl/shift_exec_stage.sv
// RV64 shift execute stage: decode + shamt mask into S1, registered Shift result in S2,
// valid/ready on both sides with full-throughput backpressure and synchronous flush.
module shift_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic            in_is_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_err
);

    shift_ctl_e      dec_ctl, s1_ctl;
    logic            dec_err, s1_err, s2_err;
    logic [5:0]      dec_shamt, s1_shamt;
    logic            s1_valid, s2_valid, s2_adv, in_fire;
    logic [XLEN-1:0] s1_rs1, s2_data, shift_res;
    logic [4:0]      s1_rd, s2_rd;
    logic            rs2_unused;

    assign rs2_unused = ^in_rs2[XLEN-1:6];

    always_comb begin
        dec_ctl = LOGICAL_LEFT64;
        dec_err = 1'b0;
        case (in_funct3)
            F3_SLL: begin
                if (in_is_word) dec_ctl = LOGICAL_LEFT32;
                else            dec_ctl = LOGICAL_LEFT64;
            end
            F3_SR: begin
                if (in_funct7_5) begin
                    if (in_is_word) dec_ctl = ARITH_RIGHT32;
                    else            dec_ctl = ARITH_RIGHT64;
                end else begin
                    if (in_is_word) dec_ctl = LOGICAL_RIGHT32;
                    else            dec_ctl = LOGICAL_RIGHT64;
                end
            end
            default: dec_err = 1'b1;
        endcase
        dec_shamt = in_is_word ? {1'b0, in_rs2[4:0]} : in_rs2[5:0];
    end

    // in_ready depends combinationally on out_ready so a full pipe can stream.
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    Shift #(.XLEN(XLEN)) u_shift (
        .src1          (s1_rs1),
        .src2          ({{(XLEN-6){1'b0}}, s1_shamt}),
        .shift_control (s1_ctl),
        .shift_out     (shift_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ctl   <= LOGICAL_LEFT64;
            s1_shamt <= '0;
            s1_rs1   <= '0;
            s1_rd    <= '0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_rd    <= '0;
            s2_err   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_err ? '0 : shift_res;
                    s2_rd   <= s1_rd;
                    s2_err  <= s1_err;
                end
            end
            // S1 refills whenever it is empty or draining into S2 this edge.
            if (in_ready) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_ctl   <= dec_ctl;
                    s1_shamt <= dec_shamt;
                    s1_rs1   <= in_rs1;
                    s1_rd    <= in_rd;
                    s1_err   <= dec_err;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_rd    = s2_rd;
    assign out_err   = s2_err;

endmodule
